// File: rtl/mag_comp_serial.sv
// mag_comp_serial: multi-cycle MSB-first slice-serial magnitude comparator with signed mode and 7485-style cascade.
// Ports: clk, rst (sync, active-high); start/a/b/signed_mode/lt_in/eq_in/gt_in sampled when idle;
//        busy while comparing; done pulses one cycle as registered lt/eq/gt become valid.
module mag_comp_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  localparam int NSL = WIDTH / SLICE;
  localparam int IW = NSL > 1 ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] TOP = IW'(NSL - 1);
  localparam logic [SLICE-1:0] MSB = SLICE'(1) << (SLICE - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic rsm;
  logic [2:0] rcas, res, res_n;
  logic [IW-1:0] idx, idx_n;
  logic done_n, load;
  logic [SLICE-1:0] flip, sa, sb;
  assign load = state == IDLE && start;
  assign busy = state == RUN;
  assign {lt, eq, gt} = res;
  // Flipping the sign bit of the top slice turns a two's-complement compare into an unsigned one.
  assign flip = (rsm && idx == TOP) ? MSB : '0;
  assign sa = ra[int'(idx)*SLICE +: SLICE] ^ flip;
  assign sb = rb[int'(idx)*SLICE +: SLICE] ^ flip;
  always_comb begin
    state_n = state;
    idx_n = idx;
    res_n = res;
    done_n = 1'b0;
    if (load) begin
      state_n = RUN;
      idx_n = TOP;
      res_n = '0;
    end else if (busy) begin
      if (sa != sb || idx == '0) begin
        state_n = IDLE;
        done_n = 1'b1;
        res_n = sa > sb ? 3'b001 : sa < sb ? 3'b100 : rcas;
      end else begin
        idx_n = idx - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= TOP;
      res <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      res <= res_n;
      done <= done_n;
    end
  end
  always_ff @(posedge clk) begin
    if (load) begin
      ra <= a;
      rb <= b;
      rsm <= signed_mode;
      rcas <= {lt_in, eq_in, gt_in};
    end
  end
endmodule
